commit_trace_buffer: RTL

- Parametrised successor to the single-lane commit/exception monitor.
- Accepts up to COMMIT_W retired instructions plus one exception/ertn event per cycle, packs them in order into a FIFO, and drains one record per cycle over a valid/ready port to a trace consumer (difftest shim or debug port).
- Adds overflow accounting, retire counters and a no-commit watchdog.
- Sits beside the writeback stage; purely observational, never stalls the core.

---
 rtl/trace_pkg.sv | 30 +++
 rtl/trace_fifo.sv | 66 ++++++
 rtl/commit_trace_buffer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared record types and constants for the commit trace
//                buffer (record kind encoding, packed trace record).
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Record kind as it appears on trace_kind
    typedef enum logic [1:0] {
        INST = 2'd0,
        EXC  = 2'd1,
        ERTN = 2'd2
    } trace_kind_e;

    // One FIFO entry; word/pc meaning depends on kind
    typedef struct packed {
        trace_kind_e kind;
        logic        inv;
        logic [31:0] word;
        logic [31:0] pc;
    } trace_rec_t;

    localparam int TRACE_DROP_W = 16;

    localparam trace_rec_t c_rec_zero = '{kind: INST, inv: 1'b0, word: 32'd0, pc: 32'd0};

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Multi-push (up to NPUSH compacted records per cycle),
//                single-pop FIFO. The caller guarantees a push fits; the
//                head output holds the last popped record while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter int NPUSH = 3,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NPUSH+1)-1:0]   i_push_n,
    input  trace_rec_t [NPUSH-1:0]       i_push_rec,
    input  logic                         i_pop,
    output trace_rec_t                   o_head,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    trace_rec_t             r_mem [DEPTH];
    trace_rec_t             r_last;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Write the first i_push_n records into consecutive slots (storage is not reset)
    always_ff @(posedge clk) begin
        for (int j = 0; j < NPUSH; j++) begin
            if (!rst && (j < int'(i_push_n))) begin
                r_mem[r_wr_ptr + c_ptr_w'(j)] <= i_push_rec[j];
            end
        end
    end

    // Pointers, occupancy and the held copy of the most recently popped record
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_last   <= c_rec_zero;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(i_push_n);
            r_count  <= r_count + c_cnt_w'(i_push_n) - c_cnt_w'(w_pop);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : r_last;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_buffer
//  Description : Packs up to COMMIT_W retired instructions plus one
//                exception/ertn event per cycle into a trace FIFO, drains
//                one record per cycle, and keeps overflow, retire and
//                no-commit watchdog accounting. Purely observational.
//                Optional macro TRACE_DPI_EN: forces the consumer side
//                always ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 16,
    parameter int WATCHDOG = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_W-1:0]     cmt_valid,
    input  logic [COMMIT_W-1:0]     cmt_inv,
    input  logic [32*COMMIT_W-1:0]  cmt_inst,
    input  logic [32*COMMIT_W-1:0]  cmt_pc,
    input  logic                    ex,
    input  logic                    ertn,
    input  logic [5:0]              ecode,
    input  logic [8:0]              esubcode,
    input  logic [31:0]             ex_pc,
    output logic                    trace_valid,
    input  logic                    trace_ready,
    output logic [1:0]              trace_kind,
    output logic                    trace_inv,
    output logic [31:0]             trace_word,
    output logic [31:0]             trace_pc,
    output logic                    overflow,
    output logic [TRACE_DROP_W-1:0] drop_cnt,
    output logic [63:0]             retire_cnt,
    output logic                    hang
);

    localparam int c_nrec   = COMMIT_W + 1;
    localparam int c_n_w    = $clog2(COMMIT_W + 2);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_lane_w = $clog2(COMMIT_W + 1);
    localparam int c_wd_w   = $clog2(WATCHDOG + 1);

    trace_rec_t [c_nrec-1:0] w_rec;
    logic [c_n_w-1:0]        w_n;
    logic [c_n_w-1:0]        w_push_n;
    logic [c_lane_w-1:0]     w_ret_n;
    logic [c_cnt_w-1:0]      w_count;
    logic [c_cnt_w-1:0]      w_free;
    logic                    w_drop;
    logic                    w_ready;
    logic                    w_pop;
    trace_rec_t              w_head;
    logic [c_wd_w-1:0]       w_wd_next;

    logic                    r_overflow;
    logic [TRACE_DROP_W-1:0] r_drop_cnt;
    logic [63:0]             r_retire_cnt;
    logic [c_wd_w-1:0]       r_wd;
    logic                    r_hang;

    // Compact valid lanes in ascending order, then append the event record (ex wins over ertn)
    always_comb begin
        for (int k = 0; k < c_nrec; k++) begin
            w_rec[k] = c_rec_zero;
        end
        w_n     = '0;
        w_ret_n = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (cmt_valid[i]) begin
                w_rec[w_n] = '{kind: INST, inv: cmt_inv[i],
                               word: cmt_inst[32*i +: 32], pc: cmt_pc[32*i +: 32]};
                w_n = w_n + c_n_w'(1);
                if (!cmt_inv[i]) begin
                    w_ret_n = w_ret_n + c_lane_w'(1);
                end
            end
        end
        if (ex) begin
            w_rec[w_n] = '{kind: EXC, inv: 1'b0, word: {17'b0, esubcode, ecode}, pc: ex_pc};
            w_n = w_n + c_n_w'(1);
        end else if (ertn) begin
            w_rec[w_n] = '{kind: ERTN, inv: 1'b0, word: 32'd0, pc: ex_pc};
            w_n = w_n + c_n_w'(1);
        end
    end

    // All-or-nothing push against free space measured before this cycle's pop
    assign w_free   = c_cnt_w'(DEPTH) - w_count;
    assign w_drop   = c_cnt_w'(w_n) > w_free;
    assign w_push_n = w_drop ? '0 : w_n;

    assign trace_valid = (w_count != '0);
    assign w_pop       = trace_valid && w_ready;

    trace_fifo #(
        .NPUSH (c_nrec),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clock),
        .rst        (reset),
        .i_push_n   (w_push_n),
        .i_push_rec (w_rec),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    assign trace_kind = w_head.kind;
    assign trace_inv  = w_head.inv;
    assign trace_word = w_head.word;
    assign trace_pc   = w_head.pc;

`ifdef TRACE_DPI_EN
    assign w_ready = trace_ready | 1'b1;
`else
    assign w_ready = trace_ready;
`endif

    // Watchdog: any committing lane clears it, otherwise count up and hold at the limit
    assign w_wd_next = (|cmt_valid)                    ? '0   :
                       (r_wd == c_wd_w'(WATCHDOG))     ? r_wd :
                                                         r_wd + c_wd_w'(1);

    // Overflow, drop, retire and hang accounting
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_retire_cnt <= '0;
            r_wd         <= '0;
            r_hang       <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + TRACE_DROP_W'(1);
                end
            end
            r_retire_cnt <= r_retire_cnt + 64'(w_ret_n);
            r_wd         <= w_wd_next;
            if (w_wd_next == c_wd_w'(WATCHDOG)) begin
                r_hang <= 1'b1;
            end
        end
    end

    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;
    assign retire_cnt = r_retire_cnt;
    assign hang       = r_hang;

endmodule
`default_nettype wire
